// File: rtl/firc_sym_param.sv
// Complex symmetric FIR: folded delay line, one complex MAC per cycle over the
// unique taps, double-buffered coefficient banks, rounded/saturated output.
module firc_rnd_sat #(
  parameter int IW = 57,
  parameter int OW = 32,
  parameter int SH = 23
) (
  input  logic [IW-1:0] a,
  output logic [OW-1:0] y
);
  localparam logic signed [IW:0] RND  = (IW+1)'(1) << (SH-1);
  localparam logic signed [IW:0] MAXV = {{(IW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW:0] MINV = {{(IW+2-OW){1'b1}}, {(OW-1){1'b0}}};

  logic signed [IW:0] r, q;

  always_comb begin
    r = $signed({a[IW-1], a}) + RND;
    q = r >>> SH;
    if (q > MAXV)      y = MAXV[OW-1:0];
    else if (q < MINV) y = MINV[OW-1:0];
    else               y = q[OW-1:0];
  end
endmodule

module firc_sym_param #(
  parameter int NTAPS    = 29,
  parameter int SW       = 24,
  parameter int CW       = 27,
  parameter int OW       = 32,
  parameter int OUT_FRAC = 24,
  parameter int AW       = 5
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 PushIn,
  output logic                 StopIn,
  input  logic signed [SW-1:0] SampI,
  input  logic signed [SW-1:0] SampQ,
  input  logic                 PushCoef,
  input  logic [AW-1:0]        CoefAddr,
  input  logic signed [CW-1:0] CoefI,
  input  logic signed [CW-1:0] CoefQ,
  input  logic                 CoefSwap,
  output logic                 PushOut,
  input  logic                 StopOut,
  output logic [OW-1:0]        FI,
  output logic [OW-1:0]        FQ
);
  localparam int NHALF = (NTAPS + 1) / 2;
  localparam int KW    = $clog2(NHALF);
  localparam int ACCW  = SW + CW + 2 + $clog2(NHALF);
  localparam int PW    = SW + CW + 1;
  localparam int SH    = SW + CW - 4 - OUT_FRAC;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]            state;
  logic [KW-1:0]         k;
  logic                  sel, pend, leave;
  logic signed [SW-1:0]  xi [NTAPS];
  logic signed [SW-1:0]  xq [NTAPS];
  logic signed [CW-1:0]  bci [2][NHALF];
  logic signed [CW-1:0]  bcq [2][NHALF];
  logic signed [SW:0]    fi [NHALF];
  logic signed [SW:0]    fq [NHALF];
  logic signed [CW-1:0]  ci, cq;
  logic signed [SW:0]    si, sq;
  logic signed [PW-1:0]  pii, pqq, piq, pqi;
  logic [1:0][ACCW-1:0]  acc, acc_nxt;
  logic [1:0][OW-1:0]    fo, sat;

  assign StopIn = (state != IDLE);
  assign leave  = (state == HOLD) && !StopOut;
  assign FI     = fo[0];
  assign FQ     = fo[1];

  // Fold mirrored taps; the centre tap has no partner.
  for (genvar j = 0; j < NHALF; j++) begin : g_fold
    if (j < NHALF-1) begin : g_pair
      assign fi[j] = (SW+1)'(xi[j]) + (SW+1)'(xi[NTAPS-1-j]);
      assign fq[j] = (SW+1)'(xq[j]) + (SW+1)'(xq[NTAPS-1-j]);
    end else begin : g_ctr
      assign fi[j] = (SW+1)'(xi[j]);
      assign fq[j] = (SW+1)'(xq[j]);
    end
  end

  always_comb begin
    ci  = bci[sel][k];
    cq  = bcq[sel][k];
    si  = fi[k];
    sq  = fq[k];
    pii = PW'(ci) * PW'(si);
    pqq = PW'(cq) * PW'(sq);
    piq = PW'(ci) * PW'(sq);
    pqi = PW'(cq) * PW'(si);
    acc_nxt[0] = $signed(acc[0]) + ACCW'(pii) - ACCW'(pqq);
    acc_nxt[1] = $signed(acc[1]) + ACCW'(piq) + ACCW'(pqi);
  end

  for (genvar l = 0; l < 2; l++) begin : g_lane
    firc_rnd_sat #(.IW(ACCW), .OW(OW), .SH(SH)) u_rs (.a(acc_nxt[l]), .y(sat[l]));
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state   <= IDLE;
      k       <= '0;
      sel     <= 1'b0;
      pend    <= 1'b0;
      PushOut <= 1'b0;
      acc     <= '0;
      fo      <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        xi[i] <= '0;
        xq[i] <= '0;
      end
      for (int b = 0; b < 2; b++)
        for (int j = 0; j < NHALF; j++) begin
          bci[b][j] <= '0;
          bcq[b][j] <= '0;
        end
    end else begin
      // Writes always target the bank that is shadow before any swap this cycle.
      if (PushCoef && int'(CoefAddr) < NHALF) begin
        bci[~sel][CoefAddr[KW-1:0]] <= CoefI;
        bcq[~sel][CoefAddr[KW-1:0]] <= CoefQ;
      end
      unique case (state)
        IDLE: if (PushIn) begin
          for (int i = NTAPS-1; i > 0; i--) begin
            xi[i] <= xi[i-1];
            xq[i] <= xq[i-1];
          end
          xi[0] <= SampI;
          xq[0] <= SampQ;
          acc   <= '0;
          k     <= '0;
          state <= ACC;
        end
        ACC: begin
          acc <= acc_nxt;
          k   <= k + 1'b1;
          if (k == KW'(NHALF-1)) begin
            fo      <= sat;
            PushOut <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: if (!StopOut) begin
          PushOut <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Bank select only moves while no sample is in flight.
      if ((state == IDLE && CoefSwap) || (leave && (pend || CoefSwap))) begin
        sel  <= ~sel;
        pend <= 1'b0;
      end else if (CoefSwap) begin
        pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_firc_sym_param.sv
// Bench for firc_sym_param: directed + random samples against a direct-form
// complex convolution model with explicit bank bookkeeping.
module tb_firc_sym_param;
  localparam int NTAPS = 29, NHALF = 15, SW = 24, CW = 27, OW = 32, OUT_FRAC = 24, AW = 5;
  localparam int SH = SW + CW - 4 - OUT_FRAC;

  logic                 Clk = 1'b0, Reset_n = 1'b0, PushIn = 1'b0, StopIn;
  logic signed [SW-1:0] SampI = '0, SampQ = '0;
  logic                 PushCoef = 1'b0, CoefSwap = 1'b0, PushOut, StopOut = 1'b0;
  logic [AW-1:0]        CoefAddr = '0;
  logic signed [CW-1:0] CoefI = '0, CoefQ = '0;
  logic [OW-1:0]        FI, FQ;

  firc_sym_param #(.NTAPS(NTAPS), .SW(SW), .CW(CW), .OW(OW), .OUT_FRAC(OUT_FRAC), .AW(AW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .PushIn(PushIn), .StopIn(StopIn),
    .SampI(SampI), .SampQ(SampQ), .PushCoef(PushCoef), .CoefAddr(CoefAddr),
    .CoefI(CoefI), .CoefQ(CoefQ), .CoefSwap(CoefSwap), .PushOut(PushOut),
    .StopOut(StopOut), .FI(FI), .FQ(FQ)
  );

  always #5 Clk = ~Clk;

  int npass = 0, nfail = 0, ntot = 0;
  longint mci [2][NHALF];
  longint mcq [2][NHALF];
  longint hi [NTAPS];
  longint hq [NTAPS];
  int msel;
  logic [31:0] exp_i, exp_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int j = 0; j < NHALF; j++) begin
        mci[b][j] = 0;
        mcq[b][j] = 0;
      end
    for (int i = 0; i < NTAPS; i++) begin
      hi[i] = 0;
      hq[i] = 0;
    end
    msel = 0;
  endtask

  function automatic logic [31:0] rsat(input longint a);
    longint r, lim;
    lim = longint'(1) <<< (OW-1);
    r = (a + (longint'(1) <<< (SH-1))) >>> SH;
    if (r > lim - 1) r = lim - 1;
    if (r < -lim) r = -lim;
    return r[31:0];
  endfunction

  // Direct-form complex convolution with the mirrored coefficient set.
  task automatic model_calc(output logic [31:0] oi, output logic [31:0] oq);
    longint ai, aq;
    int kk;
    ai = 0;
    aq = 0;
    for (int i = 0; i < NTAPS; i++) begin
      kk = (i < NTAPS-1-i) ? i : NTAPS-1-i;
      ai += mci[msel][kk] * hi[i] - mcq[msel][kk] * hq[i];
      aq += mci[msel][kk] * hq[i] + mcq[msel][kk] * hi[i];
    end
    oi = rsat(ai);
    oq = rsat(aq);
  endtask

  function automatic logic [26:0] rc();
    return 27'($urandom);
  endfunction

  function automatic logic [23:0] rsamp();
    return 24'($urandom);
  endfunction

  // swp: 0 none, 1 swap now (IDLE), 2 swap pulse while busy (model swaps later)
  task automatic load(input int addr, input logic [26:0] ci, input logic [26:0] cq, input int swp);
    logic signed [26:0] sci, scq;
    sci = ci;
    scq = cq;
    PushCoef = 1'b1;
    CoefAddr = 5'(addr);
    CoefI = ci;
    CoefQ = cq;
    CoefSwap = (swp != 0);
    if (addr < NHALF) begin
      mci[1-msel][addr] = sci;
      mcq[1-msel][addr] = scq;
    end
    if (swp == 1) msel = 1 - msel;
    @(negedge Clk);
    PushCoef = 1'b0;
    CoefSwap = 1'b0;
  endtask

  task automatic swap_now();
    CoefSwap = 1'b1;
    msel = 1 - msel;
    @(negedge Clk);
    CoefSwap = 1'b0;
  endtask

  task automatic accept(input logic [23:0] si, input logic [23:0] sq, input int swp);
    int n;
    logic signed [23:0] ssi, ssq;
    n = 0;
    while (StopIn !== 1'b0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    check("accept_ready", {31'b0, StopIn}, 32'd0);
    PushIn = 1'b1;
    SampI = si;
    SampQ = sq;
    CoefSwap = (swp != 0);
    if (swp != 0) msel = 1 - msel;
    for (int i = NTAPS-1; i > 0; i--) begin
      hi[i] = hi[i-1];
      hq[i] = hq[i-1];
    end
    ssi = si;
    ssq = sq;
    hi[0] = ssi;
    hq[0] = ssq;
    model_calc(exp_i, exp_q);
    @(negedge Clk);
    PushIn = 1'b0;
    CoefSwap = 1'b0;
  endtask

  task automatic expect_out(input int lat);
    int n;
    n = 0;
    while (PushOut !== 1'b1 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("latency", n, lat);
    check("fi", FI, exp_i);
    check("fq", FQ, exp_q);
    if (StopOut === 1'b0) begin
      @(negedge Clk);
      check("done_pushout", {31'b0, PushOut}, 32'd0);
      check("done_stopin", {31'b0, StopIn}, 32'd0);
    end
  endtask

  initial begin
    int m;
    logic [31:0] hold_i, hold_q;
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_pushout", {31'b0, PushOut}, 32'd0);
    check("rst_stopin", {31'b0, StopIn}, 32'd0);
    check("rst_fi", FI, 32'd0);
    check("rst_fq", FQ, 32'd0);
    Reset_n = 1'b1;

    // Real impulse through a ramp coefficient set.
    for (int k = 0; k < NHALF; k++) load(k, 27'((k+1) << 20), 27'd0, 0);
    swap_now();
    for (int n = 0; n < 30; n++) begin
      accept((n == 0) ? 24'h400000 : 24'h0, 24'h0, 0);
      expect_out(NHALF);
      m = (n + 1 < NTAPS - n) ? n + 1 : NTAPS - n;
      check("imp_fi", FI, (n < NTAPS) ? 32'(m) * 32'h00080000 : 32'd0);
      check("imp_fq", FQ, 32'd0);
    end

    // Purely imaginary coefficients.
    for (int k = 0; k < NHALF; k++) load(k, 27'd0, 27'(1 << 24), 0);
    swap_now();
    accept(24'h400000, 24'h0, 0);
    expect_out(NHALF);
    check("cplx_fq", FQ, 32'h00800000);
    check("cplx_fi", FI, 32'd0);
    accept(24'h0, 24'h400000, 0);
    expect_out(NHALF);
    check("cplx_fi_q", FI, 32'hFF800000);

    // Random bank; out-of-range writes, last real write shares a cycle with the swap.
    for (int k = 0; k < NHALF-1; k++) load(k, rc(), rc(), 0);
    for (int a = NHALF; a < 32; a++) load(a, rc(), rc(), 0);
    load(NHALF-1, rc(), rc(), 1);
    for (int n = 0; n < 20; n++) begin
      accept(rsamp(), rsamp(), 0);
      expect_out(NHALF);
    end

    // Swap and accept on the same edge: the sample uses the new bank.
    for (int k = 0; k < NHALF; k++) load(k, rc(), rc(), 0);
    accept(rsamp(), rsamp(), 1);
    expect_out(NHALF);
    for (int n = 0; n < 3; n++) begin
      accept(rsamp(), rsamp(), 0);
      expect_out(NHALF);
    end

    // Swap requested mid-flight, with a duplicate pulse that must collapse.
    for (int k = 0; k < NHALF; k++) load(k, rc(), rc(), 0);
    accept(rsamp(), rsamp(), 0);
    load(3, rc(), rc(), 2);
    CoefSwap = 1'b1;
    @(negedge Clk);
    CoefSwap = 1'b0;
    expect_out(NHALF - 2);
    msel = 1 - msel;
    for (int n = 0; n < 3; n++) begin
      accept(rsamp(), rsamp(), 0);
      expect_out(NHALF);
    end

    // Back-pressure in HOLD; pushes meanwhile are ignored.
    StopOut = 1'b1;
    accept(rsamp(), rsamp(), 0);
    expect_out(NHALF);
    hold_i = exp_i;
    hold_q = exp_q;
    for (int c = 0; c < 10; c++) begin
      PushIn = 1'b1;
      SampI = rsamp();
      SampQ = rsamp();
      @(negedge Clk);
      check("bp_pushout", {31'b0, PushOut}, 32'd1);
      check("bp_fi", FI, hold_i);
      check("bp_fq", FQ, hold_q);
      check("bp_stopin", {31'b0, StopIn}, 32'd1);
    end
    PushIn = 1'b0;
    StopOut = 1'b0;
    @(negedge Clk);
    check("bp_release_pushout", {31'b0, PushOut}, 32'd0);
    check("bp_release_stopin", {31'b0, StopIn}, 32'd0);
    for (int n = 0; n < 2; n++) begin
      accept(rsamp(), rsamp(), 0);
      expect_out(NHALF);
    end

    // Saturation, both polarities.
    for (int k = 0; k < NHALF; k++) load(k, 27'h3FFFFFF, 27'h3FFFFFF, 0);
    swap_now();
    for (int n = 0; n < NTAPS; n++) begin
      accept(24'h7FFFFF, 24'h7FFFFF, 0);
      expect_out(NHALF);
    end
    check("sat_pos_fq", FQ, 32'h7FFFFFFF);
    check("sat_pos_fi", FI, 32'd0);
    for (int n = 0; n < NTAPS; n++) begin
      accept(24'h800000, 24'h800000, 0);
      expect_out(NHALF);
    end
    check("sat_neg_fq", FQ, 32'h80000000);
    check("sat_neg_fi", FI, 32'd0);

    // Reset in the middle of an accumulation.
    accept(rsamp(), rsamp(), 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    check("midrst_pushout", {31'b0, PushOut}, 32'd0);
    check("midrst_stopin", {31'b0, StopIn}, 32'd0);
    check("midrst_fi", FI, 32'd0);
    check("midrst_fq", FQ, 32'd0);
    for (int k = 0; k < NHALF; k++) load(k, 27'((k+1) << 20), 27'd0, 0);
    swap_now();
    for (int n = 0; n < 6; n++) begin
      accept((n == 0) ? 24'h400000 : 24'h0, 24'h0, 0);
      expect_out(NHALF);
      check("postrst_imp_fi", FI, 32'(n + 1) * 32'h00080000);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
